bram_load_arbiter: RTL and testbench

BRAM_LOAD_ARBITER -- requirements
Module: bram_load_arbiter

---
 rtl/bram_load_arbiter_pkg.sv | 18 +
 rtl/bram_load_arbiter_rr.sv | 36 +++
 rtl/bram_load_arbiter.sv | 155 +++++++++++++++
 tb/tb_bram_load_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_load_arbiter_pkg.sv
// Shared definitions for the BRAM load arbiter and the loaders that consume
// its read stream: FSM state encoding, default BRAM read latency and a small
// helper for index widths.
package bram_load_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int BLA_RD_LAT = 2;

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_load_arbiter_rr.sv
// rr_select: round-robin priority selector.
// Ports:
//   req        - request vector
//   last       - index of the previous winner; search starts at last+1
//   winner     - one-hot winner (all zero when no request)
//   winner_idx - binary index of the winner (zero when no request)
module rr_select #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] winner,
  output logic [IW-1:0]    winner_idx
);

  logic found;
  int   j;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    j          = 0;
    // Walk upward from last+1; the requester at 'last' is visited last.
    for (int i = 1; i <= N_REQ; i++) begin
      j = (int'(last) + i) % N_REQ;
      if (!found && req[j]) begin
        found      = 1'b1;
        winner[j]  = 1'b1;
        winner_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bram_load_arbiter.sv
// bram_load_arbiter: grants one loader at a time a read burst on a shared,
// read-only BRAM port and streams the returned words back tagged with the
// owner and the word index.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   req, req_base, req_len   - per-requester level request, packed start
//                              addresses and word counts
//   grant, req_done          - one-hot burst owner, one-cycle completion pulse
//   data_valid, data_out,
//   data_idx, data_owner     - returned word stream
//   bram_en, bram_ren,
//   bram_wen, bram_addr,
//   bram_din, bram_dout      - external BRAM port (write side tied off)
module bram_load_arbiter
  import bram_load_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int LEN_WIDTH  = 19,
  parameter int RD_LAT     = BLA_RD_LAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_base,
  input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            req_done,
  output logic                        data_valid,
  output logic [W-1:0]                data_out,
  output logic [LEN_WIDTH-1:0]        data_idx,
  output logic [N_REQ-1:0]            data_owner,
  output logic                        bram_en,
  output logic                        bram_ren,
  output logic                        bram_wen,
  output logic [ADDR_WIDTH-1:0]       bram_addr,
  output logic [W-1:0]                bram_din,
  input  logic [W-1:0]                bram_dout
);

  localparam int IW = idx_w(N_REQ);

  logic [1:0]            state;
  logic [N_REQ-1:0]      owner;
  logic [IW-1:0]         owner_idx;
  logic [IW-1:0]         last_winner;
  logic [LEN_WIDTH-1:0]  count;
  logic [LEN_WIDTH-1:0]  issue_idx;
  logic [RD_LAT-1:0]     rd_vld_p;
  logic [LEN_WIDTH-1:0]  rd_idx_p [RD_LAT];

  logic [N_REQ-1:0]      sel_onehot;
  logic [IW-1:0]         sel_idx;
  logic [ADDR_WIDTH-1:0] sel_base;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic                  issue;
  logic                  pending;

  rr_select #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .req        (req),
    .last       (last_winner),
    .winner     (sel_onehot),
    .winner_idx (sel_idx)
  );

  assign sel_base = req_base[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_len  = req_len[int'(sel_idx)*LEN_WIDTH +: LEN_WIDTH];
  assign issue    = (state == ST_ISSUE);

  // Reads still in flight after the current cycle; the last stage is the
  // beat being presented now, so it is excluded.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pending = pending | rd_vld_p[i];
    end
  end

  // Control: FSM, burst owner, arbitration history and address counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= '0;
      owner_idx   <= '0;
      last_winner <= IW'(N_REQ - 1);
      bram_addr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            owner     <= sel_onehot;
            owner_idx <= sel_idx;
            bram_addr <= sel_base;
            state     <= (sel_len == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bram_addr <= bram_addr + ADDR_WIDTH'(1);
          if (count == LEN_WIDTH'(1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!pending) state <= ST_DONE;
        end
        default: begin
          last_winner <= owner_idx;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  // Burst word counters; only consulted while a burst is active, and always
  // reloaded at the grant edge.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      count     <= sel_len;
      issue_idx <= '0;
    end else if (issue) begin
      count     <= count - LEN_WIDTH'(1);
      issue_idx <= issue_idx + LEN_WIDTH'(1);
    end
  end

  // Read-return pipeline p0..p(RD_LAT-1): valid bit per issued read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p <= '0;
    end else begin
      rd_vld_p[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) rd_vld_p[i] <= rd_vld_p[i-1];
    end
  end

  // Read-return pipeline p0..p(RD_LAT-1): word index travelling with valid.
  always_ff @(posedge clk) begin
    rd_idx_p[0] <= issue_idx;
    for (int i = 1; i < RD_LAT; i++) rd_idx_p[i] <= rd_idx_p[i-1];
  end

  assign grant      = (state == ST_ISSUE || state == ST_DRAIN) ? owner : '0;
  assign req_done   = (state == ST_DONE) ? owner : '0;
  assign bram_en    = (state == ST_ISSUE || state == ST_DRAIN);
  assign bram_ren   = issue;
  assign bram_wen   = 1'b0;
  assign bram_din   = '0;
  assign data_valid = rd_vld_p[RD_LAT-1];
  assign data_out   = data_valid ? bram_dout : '0;
  assign data_idx   = data_valid ? rd_idx_p[RD_LAT-1] : '0;
  assign data_owner = data_valid ? owner : '0;

endmodule

// File: tb/tb_bram_load_arbiter.sv
module tb_bram_load_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [71:0] req_base = '0;
  logic [75:0] req_len = '0;
  logic [3:0]  grant, req_done, data_owner;
  logic        data_valid, bram_en, bram_ren, bram_wen;
  logic [7:0]  data_out, bram_din;
  logic [7:0]  bram_dout = '0;
  logic [18:0] data_idx;
  logic [17:0] bram_addr;
  logic [7:0]  mem_p1 = '0;

  bram_load_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_base(req_base), .req_len(req_len),
    .grant(grant), .req_done(req_done), .data_valid(data_valid),
    .data_out(data_out), .data_idx(data_idx), .data_owner(data_owner),
    .bram_en(bram_en), .bram_ren(bram_ren), .bram_wen(bram_wen),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'h3C;
  endfunction

  // Two-cycle-latency BRAM model.
  always @(posedge clk) begin
    mem_p1    <= mem(bram_addr);
    bram_dout <= mem_p1;
  end

  typedef struct { int owner; int idx; logic [17:0] addr; bit gap; } rd_t;
  typedef struct { logic [7:0] data; int idx; int owner; int due; } beat_t;
  typedef struct { int owner; bit len0; } done_t;
  typedef struct {
    logic [3:0]      req;
    logic [71:0]     base;
    logic [75:0]     len;
    logic [7:0][1:0] order;
    int              nb;
  } vec_t;

  rd_t   rdq[$];
  beat_t bq[$];
  done_t dq[$];
  vec_t  vt[6];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, last_ren = 0, last_done = 0, last_beat = 0;
  int done_seen = 0, rd_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    rd_t e; beat_t b; done_t d;
    chk("wen_zero", 64'(bram_wen), 0);
    chk("din_zero", 64'(bram_din), 0);
    chk("spurious_read", 64'(bram_ren && rdq.size() == 0), 0);
    if (bram_ren && rdq.size() != 0) begin
      e = rdq.pop_front();
      chk("rd_addr", 64'(bram_addr), 64'(e.addr));
      chk("rd_grant", 64'(grant), 64'(4'b0001 << e.owner));
      chk("rd_en", 64'(bram_en), 1);
      if (e.idx != 0) chk("rd_contig", 64'(cyc), 64'(last_ren + 1));
      else if (e.gap) chk("idle_gap", 64'(cyc), 64'(last_done + 2));
      b.data = mem(e.addr); b.idx = e.idx; b.owner = e.owner; b.due = cyc + 2;
      bq.push_back(b);
      last_ren = cyc;
      rd_cnt++;
    end
    chk("spurious_valid", 64'(data_valid && bq.size() == 0), 0);
    if (data_valid && bq.size() != 0) begin
      b = bq.pop_front();
      chk("beat_time", 64'(cyc), 64'(b.due));
      chk("beat_data", 64'(data_out), 64'(b.data));
      chk("beat_idx", 64'(data_idx), 64'(b.idx));
      chk("beat_owner", 64'(data_owner), 64'(4'b0001 << b.owner));
      last_beat = cyc;
    end else if (bq.size() != 0 && bq[0].due <= cyc) begin
      b = bq.pop_front();
      chk("beat_present", 64'(data_valid), 1);
    end
    chk("spurious_done", 64'(req_done != 0 && dq.size() == 0), 0);
    if (req_done != 0 && dq.size() != 0) begin
      d = dq.pop_front();
      chk("done_owner", 64'(req_done), 64'(4'b0001 << d.owner));
      if (!d.len0) chk("done_time", 64'(cyc), 64'(last_beat + 1));
      last_done = cyc;
      done_seen++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic push_exp(input vec_t v);
    int r, l;
    logic [17:0] b;
    for (int k = 0; k < v.nb; k++) begin
      r = int'(v.order[k]);
      b = v.base[r*18 +: 18];
      l = int'(v.len[r*19 +: 19]);
      for (int i = 0; i < l; i++) begin
        rd_t e;
        e.owner = r; e.idx = i; e.addr = b + 18'(i); e.gap = (k > 0);
        rdq.push_back(e);
      end
      dq.push_back('{owner: r, len0: (l == 0)});
    end
  endtask

  task automatic run_vec(input vec_t v, input bit do_reset, input string nm);
    int start, n;
    if (do_reset) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    req_base = v.base;
    req_len  = v.len;
    push_exp(v);
    start = done_seen;
    req = v.req;
    n = 0;
    while (done_seen - start < v.nb && n < 400) begin
      tick();
      n++;
    end
    req = '0;
    chk({nm, "_timeout"}, 64'(done_seen - start), 64'(v.nb));
    repeat (6) tick();
    chk({nm, "_reads_left"}, 64'(rdq.size()), 0);
    chk({nm, "_beats_left"}, 64'(bq.size()), 0);
    chk({nm, "_dones_left"}, 64'(dq.size()), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_grant"}, 64'(grant), 0);
    chk({nm, "_done"}, 64'(req_done), 0);
    chk({nm, "_valid"}, 64'(data_valid), 0);
    chk({nm, "_dout"}, 64'(data_out), 0);
    chk({nm, "_idx"}, 64'(data_idx), 0);
    chk({nm, "_owner"}, 64'(data_owner), 0);
    chk({nm, "_en"}, 64'(bram_en), 0);
    chk({nm, "_ren"}, 64'(bram_ren), 0);
    chk({nm, "_addr"}, 64'(bram_addr), 0);
  endtask

  initial begin
    vec_t va;
    int n;
    // {req, base3..0, len3..0, order (2 bits per burst, burst 0 in LSBs), nb}
    vt[0] = '{4'b0001, {18'd0, 18'd0, 18'd0, 18'd147496},
              {19'd0, 19'd0, 19'd0, 19'd8}, 16'h0000, 1};
    vt[1] = '{4'b0011, {18'd0, 18'd0, 18'd200, 18'd100},
              {19'd0, 19'd0, 19'd5, 19'd3}, 16'h0004, 2};
    vt[2] = '{4'b1111, {18'd40, 18'd30, 18'd20, 18'd10},
              {19'd2, 19'd2, 19'd2, 19'd2}, 16'h00E4, 5};
    vt[3] = '{4'b0100, {18'd0, 18'd5, 18'd0, 18'd0},
              {19'd3, 19'd0, 19'd3, 19'd3}, 16'h0002, 1};
    vt[4] = '{4'b0001, {18'd0, 18'd0, 18'd0, 18'd262142},
              {19'd0, 19'd0, 19'd0, 19'd4}, 16'h0000, 1};
    vt[5] = '{4'b1010, {18'd7000, 18'd0, 18'd3000, 18'd0},
              {19'd3, 19'd0, 19'd1, 19'd0}, 16'h000D, 2};

    rst = 1'b1;
    tick();
    tick();
    chk_zero("reset_state");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vt[i], 1'b1, $sformatf("vec%0d", i));

    // Abort a burst of requester 1 after three reads.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_base = {18'd0, 18'd0, 18'd50, 18'd0};
    req_len  = {19'd0, 19'd0, 19'd8, 19'd0};
    va = '{4'b0010, req_base, req_len, 16'h0001, 1};
    push_exp(va);
    rd_cnt = 0;
    req = 4'b0010;
    n = 0;
    while (rd_cnt < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("abort_reads_seen", 64'(rd_cnt), 3);
    rst = 1'b1;
    #1;
    chk_zero("abort");
    rdq.delete();
    bq.delete();
    dq.delete();
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    n = done_seen;
    repeat (10) tick();
    chk("abort_no_done", 64'(done_seen - n), 0);

    // After the abort, requester 0 has priority again.
    va = '{4'b1001, {18'd900, 18'd0, 18'd0, 18'd500},
           {19'd2, 19'd0, 19'd0, 19'd3}, 16'h000C, 2};
    run_vec(va, 1'b0, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
